// File: rtl/filter_event_scheduler.sv
// Event scheduler after the trapezoidal shaper: threshold arming, windowed peak search,
// pile-up flagging, hold-off/re-arm and a one-deep valid/ready output register.
`timescale 1ns/1ps
module filter_event_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] filter_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic [CNT_W-1:0]  peak_window,
  input  logic [CNT_W-1:0]  holdoff,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_amplitude,
  output logic [TS_W-1:0]   ev_time,
  output logic              ev_pileup,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StSearch  = 2'd2;
  localparam logic [1:0] StHoldoff = 2'd3;

  localparam logic [TS_W-1:0]   TsOne  = TS_W'(1);
  localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);
  localparam logic [DROP_W-1:0] DropOne = DROP_W'(1);

  logic [1:0]        state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [TS_W-1:0]   peak_ts_q, peak_ts_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic              below_q, below_d;
  logic              pileup_q, pileup_d;

  logic              ev_valid_q, ev_valid_d;
  logic [DATA_W-1:0] ev_amp_q, ev_amp_d;
  logic [TS_W-1:0]   ev_time_q, ev_time_d;
  logic              ev_pileup_q, ev_pileup_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic above;
  logic emit;
  logic load;

  assign above = filter_data > threshold;

  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    peak_ts_d = peak_ts_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    below_d   = below_q;
    pileup_d  = pileup_q;
    emit      = 1'b0;
    if (!enable) begin
      // Disabling abandons any search silently; the output register is left alone.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (above) begin
            state_d   = StSearch;
            peak_d    = filter_data;
            peak_ts_d = ts_q;
            cnt_d     = peak_window;
            below_d   = 1'b0;
            pileup_d  = 1'b0;
          end
        end
        StSearch: begin
          if (cnt_q == '0) begin
            emit    = 1'b1;
            state_d = StHoldoff;
            hcnt_d  = holdoff;
          end else begin
            cnt_d = cnt_q - CntOne;
            // Strict compare keeps the earliest sample of a flat-top maximum.
            if (filter_data > peak_q) begin
              peak_d    = filter_data;
              peak_ts_d = ts_q;
            end
            if (!above) below_d = 1'b1;
            if (below_q && above) pileup_d = 1'b1;
          end
        end
        StHoldoff: begin
          if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - CntOne;
          end else if (!above) begin
            state_d = StArmed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign load = emit && (!ev_valid_q || ev_ready);

  always_comb begin
    ev_valid_d  = ev_valid_q;
    ev_amp_d    = ev_amp_q;
    ev_time_d   = ev_time_q;
    ev_pileup_d = ev_pileup_q;
    drop_d      = drop_q;
    if (load) begin
      ev_valid_d  = 1'b1;
      ev_amp_d    = peak_q;
      ev_time_d   = peak_ts_q;
      ev_pileup_d = pileup_q;
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    if (emit && ev_valid_q && !ev_ready && (drop_q != '1)) begin
      drop_d = drop_q + DropOne;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      peak_q      <= '0;
      peak_ts_q   <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      below_q     <= 1'b0;
      pileup_q    <= 1'b0;
      ev_valid_q  <= 1'b0;
      ev_amp_q    <= '0;
      ev_time_q   <= '0;
      ev_pileup_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + TsOne;
      peak_q      <= peak_d;
      peak_ts_q   <= peak_ts_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      below_q     <= below_d;
      pileup_q    <= pileup_d;
      ev_valid_q  <= ev_valid_d;
      ev_amp_q    <= ev_amp_d;
      ev_time_q   <= ev_time_d;
      ev_pileup_q <= ev_pileup_d;
      drop_q      <= drop_d;
    end
  end

  assign ev_valid     = ev_valid_q;
  assign ev_amplitude = ev_amp_q;
  assign ev_time      = ev_time_q;
  assign ev_pileup    = ev_pileup_q;
  assign drop_count   = drop_q;
  assign busy         = (state_q == StSearch) || (state_q == StHoldoff);

endmodule

// File: tb/tb_filter_event_scheduler.sv
// Directed bench for filter_event_scheduler: single pulse, ties, pile-up, backpressure,
// re-arm, enable and asynchronous reset.
`timescale 1ns/1ps
module tb_filter_event_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] filter_data;
  logic [15:0] threshold;
  logic [7:0]  peak_window;
  logic [7:0]  holdoff;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_amplitude;
  logic [31:0] ev_time;
  logic        ev_pileup;
  logic [15:0] drop_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int edges  = 0;  // edges since reset release == ts tag of the next sample
  int t_pk;

  filter_event_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .filter_data  (filter_data),
    .threshold    (threshold),
    .peak_window  (peak_window),
    .holdoff      (holdoff),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_amplitude (ev_amplitude),
    .ev_time      (ev_time),
    .ev_pileup    (ev_pileup),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] d);
    filter_data = d;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic low_steps(input int n);
    for (int i = 0; i < n; i++) step(16'd50);
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    filter_data = 16'd0;
    threshold   = 16'd100;
    peak_window = 8'd4;
    holdoff     = 8'd3;
    ev_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_amp", ev_amplitude, 0);
    check_eq("rst_time", ev_time, 0);
    check_eq("rst_pileup", ev_pileup, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    edges = 0;

    // Single pulse, W=4
    step(16'd0);
    step(16'd0);
    check_eq("armed_busy", busy, 0);
    step(16'd150);
    check_eq("search_busy", busy, 1);
    step(16'd300);
    t_pk = edges;
    step(16'd420);
    step(16'd380);
    step(16'd200);
    check_eq("pre_emit_valid", ev_valid, 0);
    step(16'd50);
    check_eq("p1_valid", ev_valid, 1);
    check_eq("p1_amp", ev_amplitude, 420);
    check_eq("p1_time", ev_time, t_pk);
    check_eq("p1_pileup", ev_pileup, 0);
    ev_ready = 1'b1;
    step(16'd50);
    check_eq("p1_accept", ev_valid, 0);
    low_steps(3);

    // Tie, W=2: earliest 300 wins
    peak_window = 8'd2;
    step(16'd150);
    t_pk = edges;
    step(16'd300);
    step(16'd300);
    step(16'd50);
    check_eq("tie_amp", ev_amplitude, 300);
    check_eq("tie_time", ev_time, t_pk);
    low_steps(4);

    // W=0: crossing sample is the peak
    peak_window = 8'd0;
    t_pk = edges;
    step(16'd150);
    check_eq("w0_not_yet", ev_valid, 0);
    step(16'd50);
    check_eq("w0_valid", ev_valid, 1);
    check_eq("w0_amp", ev_amplitude, 150);
    check_eq("w0_time", ev_time, t_pk);
    low_steps(4);

    // Pile-up, W=5
    peak_window = 8'd5;
    step(16'd200);
    t_pk = edges;
    step(16'd250);
    step(16'd90);
    step(16'd80);
    step(16'd210);
    step(16'd150);
    step(16'd50);
    check_eq("pu_amp", ev_amplitude, 250);
    check_eq("pu_time", ev_time, t_pk);
    check_eq("pu_pileup", ev_pileup, 1);
    low_steps(4);

    // Backpressure: three pulses with ev_ready low
    holdoff     = 8'd1;
    peak_window = 8'd0;
    ev_ready    = 1'b0;
    t_pk = edges;
    step(16'd200);
    step(16'd50);
    check_eq("bp_first_amp", ev_amplitude, 200);
    low_steps(2);
    step(16'd300);
    step(16'd50);
    check_eq("bp_drop1", drop_count, 1);
    low_steps(2);
    step(16'd400);
    step(16'd50);
    check_eq("bp_held_valid", ev_valid, 1);
    check_eq("bp_held_amp", ev_amplitude, 200);
    check_eq("bp_held_time", ev_time, t_pk);
    check_eq("bp_drop2", drop_count, 2);
    ev_ready = 1'b1;
    step(16'd50);
    ev_ready = 1'b0;
    check_eq("bp_accept", ev_valid, 0);
    step(16'd50);
    step(16'd500);
    step(16'd50);
    check_eq("bp_d_amp", ev_amplitude, 500);
    low_steps(2);
    step(16'd600);
    ev_ready = 1'b1;
    step(16'd50);
    ev_ready = 1'b0;
    check_eq("bp_swap_valid", ev_valid, 1);
    check_eq("bp_swap_amp", ev_amplitude, 600);
    check_eq("bp_swap_drop", drop_count, 2);
    ev_ready = 1'b1;
    step(16'd50);
    check_eq("bp_final_accept", ev_valid, 0);
    step(16'd50);

    // Re-arm blocked while signal stays above threshold
    holdoff = 8'd2;
    step(16'd200);
    step(16'd200);
    for (int i = 0; i < 10; i++) step(16'd200);
    check_eq("rearm_busy", busy, 1);
    check_eq("rearm_no_event", ev_valid, 0);
    step(16'd50);
    check_eq("rearm_armed", busy, 0);

    // enable low mid-search
    peak_window = 8'd4;
    step(16'd150);
    step(16'd300);
    check_eq("en_search", busy, 1);
    enable = 1'b0;
    step(16'd300);
    check_eq("en_idle", busy, 0);
    enable = 1'b1;
    low_steps(6);
    check_eq("en_no_event", ev_valid, 0);
    check_eq("en_drop", drop_count, 2);

    // Asynchronous reset mid-handshake
    ev_ready    = 1'b0;
    peak_window = 8'd0;
    step(16'd200);
    step(16'd50);
    check_eq("rh_valid", ev_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_valid", ev_valid, 0);
    check_eq("ar_amp", ev_amplitude, 0);
    check_eq("ar_time", ev_time, 0);
    check_eq("ar_pileup", ev_pileup, 0);
    check_eq("ar_drop", drop_count, 0);
    check_eq("ar_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    edges = 0;
    step(16'd50);
    step(16'd50);
    step(16'd150);
    step(16'd50);
    check_eq("ts_restart_valid", ev_valid, 1);
    check_eq("ts_restart_time", ev_time, 2);
    check_eq("ts_restart_amp", ev_amplitude, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_event_scheduler.md
# filter_event_scheduler

Event scheduler for the trapezoidal shaping filter output. It arms on a programmable threshold and searches a fixed window for the shaped-pulse peak. It timestamps the peak, flags pile-up, enforces a hold-off and re-arm rule, and hands each event downstream over a valid/ready handshake with a one-deep output register. It sits directly after the shaping filter and feeds the event/readout path.

## Interface
- DATA_W, 16: filter sample width; equals SIZE_FILTER_DATA; samples are unsigned.
- TS_W, 32: timestamp counter width.
- CNT_W, 8: width of peak_window and holdoff.
- DROP_W, 16: width of drop_count.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; all state clears while low.
- enable  in  1  1 = scheduler runs; 0 = force IDLE.
- filter_data  in  DATA_W  filter output, one sample per clk.
- threshold  in  DATA_W  arming threshold; sampled every cycle.
- peak_window  in  CNT_W  number of samples searched after the crossing sample.
- holdoff  in  CNT_W  minimum cycles in HOLDOFF after an emit.
- ev_valid  out  1  event present in the output register.
- ev_ready  in  1  downstream accepts when ev_valid & ev_ready.
- ev_amplitude  out  DATA_W  peak sample value.
- ev_time  out  TS_W  timestamp of the peak sample.
- ev_pileup  out  1  pile-up detected in the search window.
- drop_count  out  DROP_W  saturating count of events lost to backpressure.
- busy  out  1  state is SEARCH or HOLDOFF.

## Operation
- ts: free-running counter, +1 every clk, wraps 2^TS_W-1 -> 0. The sample presented at an edge is tagged with the ts value before that edge.
- States: IDLE, ARMED, SEARCH, HOLDOFF.
- enable=0 in any state -> IDLE at the next edge. An in-progress search is discarded with no event and no drop. The output register is unaffected and keeps its handshake.
- IDLE -> ARMED when enable=1.
- ARMED: when filter_data > threshold (strict):
  - go to SEARCH;
  - peak <= filter_data, peak_ts <= ts, cnt <= peak_window;
  - clear pileup and below flags.
- SEARCH, each edge:
  - if cnt==0: emit, then go to HOLDOFF with hcnt <= holdoff.
  - else cnt--, and the sample is compared:
    - filter_data > peak (strict) -> update peak and peak_ts; the earliest maximum wins on ties;
    - filter_data <= threshold -> below <= 1;
    - below==1 and filter_data > threshold -> pileup <= 1.
- HOLDOFF:
  - hcnt>0 -> hcnt--.
  - hcnt==0 and filter_data <= threshold -> ARMED.
  - hcnt==0 and filter_data > threshold -> stay in HOLDOFF; no re-arm until the signal returns to threshold or below.
- Emit, loading {peak, peak_ts, pileup} into the output register:
  - ev_valid=0, or ev_valid & ev_ready in the same cycle -> load, ev_valid=1.
  - ev_valid=1 & ev_ready=0 -> new event is dropped; drop_count +1, saturating at all-ones; the held event is unchanged.
- Handshake:
  - ev_valid & ev_ready with no emit -> ev_valid=0 next edge.
  - While ev_valid=1 and not accepted, all ev_* outputs are stable.
- All comparisons are unsigned, full DATA_W. The counters never underflow.

## Timing
- Reset values:
  - state=IDLE, ts=0;
  - ev_valid=0, ev_amplitude=0, ev_time=0, ev_pileup=0;
  - drop_count=0, busy=0;
  - internal peak, cnt, hcnt and flags = 0.
- Crossing sample captured at edge E0 (ARMED -> SEARCH). Samples at E1..E(W) are compared, where W=peak_window. Emit happens at edge E(W+1), so ev_valid is high after E(W+1).
  - W=0: the crossing sample is the peak; ev_valid is high after E1.
- HOLDOFF is entered at E(W+1). The earliest return to ARMED is edge E(W+1)+holdoff+1, and a new crossing can be captured one edge after that.
- ev_ready is used combinationally in the same cycle only for the accept/load decision. There is no combinational path from any input to any output.
- reset low mid-search or mid-handshake clears everything immediately. The pending event is lost and not counted.

## Test plan
- Single pulse: threshold=100, W=4, holdoff=3, samples after the crossing 150,300,420,380,200 -> ev_valid at E5; amplitude=420; ev_time=ts of 420; pileup=0.
- Tie and W=0: W=2, samples 150,300,300 -> amplitude=300 with the timestamp of the first 300. Separately, W=0 crossing at 150 -> amplitude=150, ev_valid after E1.
- Pile-up: threshold=100, W=5, samples 200,250,90,80,210,150 -> amplitude=250, pileup=1.
- Backpressure: hold ev_ready=0 across three pulses -> first event held unchanged, drop_count=2. Then ev_ready=1 for one cycle -> ev_valid=0. A fourth pulse emitting in the same cycle as an accept -> loaded, drop_count stays 2.
- Re-arm: holdoff=2 with the signal still above threshold 10 cycles after emit -> stays HOLDOFF, busy=1, no event. Signal drops to 50 -> ARMED next edge.
- Enable/reset: enable=0 mid-SEARCH -> IDLE, no event, drop_count unchanged. reset low mid-handshake -> all outputs 0 asynchronously, and ts restarts at 0.
